noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
Router input-port unit: the requester side of the 5-way round-robin output arbiters. It buffers incoming flits, computes an XY route from each head flit, and drives a one-hot request toward the chosen output. It consumes the one-hot grant, forwards granted flits to the crossbar and holds the route until the tail flit leaves. One instance per router input (local, N, E, S, W).

Parameters:
FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type, the rest is payload
DEPTH, 4, input FIFO depth in flits (power of 2, >=2)
X_W, 2, X coordinate width
Y_W, 2, Y coordinate width
MY_X, 0, this router's X coordinate
MY_Y, 0, this router's Y coordinate

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_flit  in  FLIT_W  flit from upstream link
in_valid  in  1  upstream flit valid
in_ready  out  1  FIFO can accept; transfer when in_valid&in_ready
req  out  5  one-hot request to output arbiters (0 local, 1 N, 2 E, 3 S, 4 W)
grant  in  5  one-hot grant for this input, combinational from req in the same cycle
out_ready  in  1  crossbar/downstream can accept this cycle
out_flit  out  FLIT_W  FIFO head flit
out_valid  out  1  flit transferred this cycle
pkt_active  out  1  high from route set until tail pop (wormhole lock hint for output side)
err_drop  out  1  1-cycle pulse: non-head flit dropped in IDLE

Behaviour:
- Flit type: 00 head, 01 body, 10 tail, 11 head+tail (single-flit packet).
- Head payload: dest_x = [X_W-1:0], dest_y = [X_W+Y_W-1:X_W].
- Reset: FIFO emptied (rd/wr ptr=0, count=0); state IDLE.
- Output values in reset: req=0, out_valid=0, pkt_active=0, err_drop=0, in_ready=1.
- FIFO:
  - count register of width clog2(DEPTH)+1; in_ready = (count != DEPTH), taken from registered count.
  - No write when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ACTIVE:
  - IDLE, FIFO empty: stay.
  - IDLE, front flit is head or head+tail: compute the route and register it in route_q (one-hot, 5b); go to ACTIVE next cycle. Route computation costs 1 cycle; no req in IDLE.
  - IDLE, front flit is body or tail: pop it without forwarding, pulse err_drop, stay IDLE.
  - ACTIVE: req = route_q when the FIFO is non-empty, else 0. pkt_active=1.
  - Pop/forward when (grant & route_q)!=0 and out_ready: out_valid=1, out_flit = front flit.
  - Grant present but out_ready=0: no pop, req stays asserted.
  - Popping a tail or head+tail flit: go to IDLE next cycle; pkt_active drops the same edge.
- XY routing:
  - dest_x>MY_X -> E
  - dest_x<MY_X -> W
  - else dest_y>MY_Y -> N
  - dest_y<MY_Y -> S
  - else local.
  - Comparisons are unsigned.
- Grant with a bit outside route_q, or a multi-hot grant, is ignored: no pop.
- Body flit not yet arrived mid-packet: req=0, stay ACTIVE, route retained.
- Reset mid-packet: in-flight flits discarded, state IDLE.
- Throughput: 1 flit/cycle while granted and out_ready. Head-to-first-req latency 1 cycle after the head reaches the FIFO front.

Optional Feature:
NOC_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0], which counts cycles with req!=0 and no matching grant&out_ready. It saturates at 16'hFFFF and clears on reset only.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package noc_pkg holds:
  - flit_type_e enum (HEAD, BODY, TAIL, HEADTAIL)
  - port index constants (P_LOCAL=0, P_N=1, P_E=2, P_S=3, P_W=4)
  - NUM_PORTS=5
  - flit type field position localparams
  - function xy_route(dest_x, dest_y, my_x, my_y), returning a 5b one-hot.
- One sub-module: noc_flit_fifo (synchronous FIFO, DEPTH/FLIT_W params, push/pop/full/empty/count).

Test Plan:
- MY=(1,1); send HEADTAIL dest (3,1); grant=req with out_ready=1 -> req=5'b00100 one cycle after arrival; out_valid for 1 cycle; back to IDLE; req=0.
- 4-flit packet dest (1,0): H,B,B,T; grant every cycle -> req=5'b01000 held; 4 consecutive out_valid; pkt_active falls after T.
- Grant withheld 3 cycles mid-packet, then given -> req stays 5'b01000, no pops during stall, flit order preserved, no loss.
- Fill FIFO (DEPTH=4), no grant -> in_ready=0 at count 4; 5th flit not accepted; first pop re-raises in_ready next cycle.
- BODY flit arriving while IDLE -> dropped, err_drop pulses once, req stays 0, and a following HEAD routes normally.
- Assert rst_n=0 mid-packet with 2 flits buffered -> next cycle req=0, in_ready=1, pkt_active=0; with NOC_STALL_CNT_EN, stall_cnt=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, port indices and XY route function.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;

  localparam int unsigned P_LOCAL = 0;
  localparam int unsigned P_N     = 1;
  localparam int unsigned P_E     = 2;
  localparam int unsigned P_S     = 3;
  localparam int unsigned P_W     = 4;

  // Flit type occupies the TYPE_W most-significant bits of every flit.
  localparam int unsigned TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FlitHead     = 2'b00,
    FlitBody     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_type_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_PORTS-1:0] xy_route(input int unsigned dest_x,
                                                    input int unsigned dest_y,
                                                    input int unsigned my_x,
                                                    input int unsigned my_y);
    logic [NUM_PORTS-1:0] route;
    route = '0;
    if (dest_x > my_x) begin
      route[P_E] = 1'b1;
    end else if (dest_x < my_x) begin
      route[P_W] = 1'b1;
    end else if (dest_y > my_y) begin
      route[P_N] = 1'b1;
    end else if (dest_y < my_y) begin
      route[P_S] = 1'b1;
    end else begin
      route[P_LOCAL] = 1'b1;
    end
    return route;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO; a push into a full FIFO is refused even when a pop happens alongside.
module noc_flit_fifo #(
  parameter int unsigned FLIT_W = 34,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] rdata_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o
);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, XY-routes head flits and requests/forwards under wormhole lock.
// Define NOC_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = 34,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned X_W    = 2,
  parameter int unsigned Y_W    = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLIT_W-1:0]    in_flit_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] grant_i,
  input  logic                 out_ready_i,
  output logic [FLIT_W-1:0]    out_flit_o,
  output logic                 out_valid_o,
  output logic                 pkt_active_o,
  output logic                 err_drop_o
`ifdef NOC_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] route_q, route_d;
  logic [FLIT_W-1:0]    front_flit;
  logic                 fifo_empty, fifo_pop;
  logic [CntW-1:0]      fifo_count;
  flit_type_e           front_type;
  logic                 front_is_head, front_is_tail;
  logic [X_W-1:0]       dest_x;
  logic [Y_W-1:0]       dest_y;
  logic                 fwd, drop;

  noc_flit_fifo #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (in_valid_i),
    .wdata_i(in_flit_i),
    .pop_i  (fifo_pop),
    .rdata_o(front_flit),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign in_ready_o    = (fifo_count != CntW'(DEPTH));
  assign front_type    = flit_type_e'(front_flit[FLIT_W-1 -: TYPE_W]);
  assign front_is_head = (front_type == FlitHead) || (front_type == FlitHeadTail);
  assign front_is_tail = (front_type == FlitTail) || (front_type == FlitHeadTail);
  assign dest_x        = front_flit[X_W-1:0];
  assign dest_y        = front_flit[X_W+Y_W-1:X_W];

  // Only an exact one-hot grant on our route counts; stray or multi-hot grants are ignored.
  assign fwd      = (state_q == StActive) && !fifo_empty && (grant_i == route_q) && out_ready_i;
  assign drop     = (state_q == StIdle) && !fifo_empty && !front_is_head;
  assign fifo_pop = fwd | drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && front_is_head) begin
          route_d = xy_route(32'(dest_x), 32'(dest_y), MY_X, MY_Y);
          state_d = StActive;
        end
      end
      StActive: begin
        if (fwd && front_is_tail) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_o        = '0;
    pkt_active_o = 1'b0;
    if (state_q == StActive) begin
      pkt_active_o = 1'b1;
      if (!fifo_empty) begin
        req_o = route_q;
      end
    end
    out_valid_o = fwd;
    out_flit_o  = front_flit;
    err_drop_o  = drop;
  end

`ifdef NOC_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((req_o != '0) && !fwd && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Directed self-checking bench for noc_input_port at router (1,1) with a 4-deep FIFO.
module tb_noc_input_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [33:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  req;
  logic [4:0]  grant;
  logic        out_ready = 1'b1;
  logic [33:0] out_flit;
  logic        out_valid;
  logic        pkt_active;
  logic        err_drop;
`ifdef NOC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic       grant_en = 1'b0;
  logic       use_ovr = 1'b0;
  logic [4:0] grant_ovr = '0;

  // Stand-in for the output arbiter: echo the request, or drive a forced pattern.
  always_comb grant = use_ovr ? grant_ovr : (grant_en ? req : 5'b0);

  always #5 clk = ~clk;

  noc_input_port #(
    .FLIT_W(34),
    .DEPTH (4),
    .X_W   (2),
    .Y_W   (2),
    .MY_X  (1),
    .MY_Y  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_flit_i   (in_flit),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .req_o       (req),
    .grant_i     (grant),
    .out_ready_i (out_ready),
    .out_flit_o  (out_flit),
    .out_valid_o (out_valid),
    .pkt_active_o(pkt_active),
    .err_drop_o  (err_drop)
`ifdef NOC_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fails = 0;
  int drops = 0;

  logic [33:0] tx_q[$];
  logic [33:0] rx_q[$];
  logic [33:0] exp_q[$];

  logic [4:0]  s_req;
  logic        s_valid, s_pkt, s_drop, s_ready;
  logic [33:0] s_flit;

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [7:0] tag);
    return {t, 18'b0, tag, 2'b0, dy, dx};
  endfunction

  // One clock: drive the next pending flit, sample mid-cycle, then cross the edge.
  task automatic cycle();
    in_valid = (tx_q.size() > 0);
    in_flit  = in_valid ? tx_q[0] : '0;
    #1;
    s_req   = req;
    s_valid = out_valid;
    s_pkt   = pkt_active;
    s_drop  = err_drop;
    s_ready = in_ready;
    s_flit  = out_flit;
    if (out_valid) rx_q.push_back(out_flit);
    if (err_drop) drops++;
    if (in_valid && in_ready) void'(tx_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    grant_en  = 1'b0;
    use_ovr   = 1'b0;
    out_ready = 1'b1;
    tx_q.delete();
    rx_q.delete();
    exp_q.delete();
    drops = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req !== 5'b0) begin n_fails++; $display("FAIL reset_req: got %b want %b", req, 5'b0); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (pkt_active !== 1'b0) begin n_fails++; $display("FAIL reset_pkt_active: got %b want 0", pkt_active); end
    n_checks++;
    if (err_drop !== 1'b0) begin n_fails++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef NOC_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_headtail();
    logic [33:0] f;
    do_reset();
    grant_en = 1'b1;
    f = mk(2'b11, 2'd3, 2'd1, 8'h11);
    tx_q.push_back(f);
    cycle();
    cycle();
    n_checks++;
    if (s_req !== 5'b0) begin n_fails++; $display("FAIL ht_idle_req: got %b want 00000", s_req); end
    cycle();
    n_checks++;
    if (s_req !== 5'b00100) begin n_fails++; $display("FAIL ht_req_east: got %b want 00100", s_req); end
    n_checks++;
    if (s_valid !== 1'b1 || s_flit !== f) begin
      n_fails++; $display("FAIL ht_forward: got v=%b %h want v=1 %h", s_valid, s_flit, f);
    end
    cycle();
    n_checks++;
    if (s_req !== 5'b0 || s_pkt !== 1'b0 || s_valid !== 1'b0) begin
      n_fails++; $display("FAIL ht_back_idle: got req=%b pkt=%b v=%b want 00000/0/0", s_req, s_pkt, s_valid);
    end
  endtask

  task automatic test_multi_flit();
    logic [9:0] vld_vec, pkt_vec;
    do_reset();
    grant_en = 1'b1;
    exp_q = '{mk(2'b00, 2'd1, 2'd0, 8'h21), mk(2'b01, 2'd0, 2'd0, 8'h22),
              mk(2'b01, 2'd0, 2'd0, 8'h23), mk(2'b10, 2'd0, 2'd0, 8'h24)};
    tx_q = exp_q;
    for (int i = 0; i < 10; i++) begin
      cycle();
      vld_vec[i] = s_valid;
      pkt_vec[i] = s_pkt;
      if (s_valid) begin
        n_checks++;
        if (s_req !== 5'b01000) begin n_fails++; $display("FAIL mf_req_south: got %b want 01000", s_req); end
      end
    end
    n_checks++;
    if (vld_vec !== 10'b0000111100) begin
      n_fails++; $display("FAIL mf_valid_pattern: got %b want 0000111100", vld_vec);
    end
    n_checks++;
    if (pkt_vec !== 10'b0000111100) begin
      n_fails++; $display("FAIL mf_pkt_active: got %b want 0000111100", pkt_vec);
    end
    n_checks++;
    if (rx_q !== exp_q) begin n_fails++; $display("FAIL mf_order: got %p want %p", rx_q, exp_q); end
  endtask

  task automatic test_stall();
    logic [11:0] vld_vec;
    do_reset();
    exp_q = '{mk(2'b00, 2'd1, 2'd0, 8'h31), mk(2'b01, 2'd0, 2'd0, 8'h32),
              mk(2'b01, 2'd0, 2'd0, 8'h33), mk(2'b10, 2'd0, 2'd0, 8'h34)};
    tx_q = exp_q;
    for (int i = 0; i < 12; i++) begin
      grant_en = !(i >= 3 && i <= 5);
      cycle();
      vld_vec[i] = s_valid;
      if (i >= 3 && i <= 5) begin
        n_checks++;
        if (s_req !== 5'b01000 || s_valid !== 1'b0) begin
          n_fails++; $display("FAIL stall_hold: cyc %0d got req=%b v=%b want 01000/0", i, s_req, s_valid);
        end
      end
    end
    n_checks++;
    if (vld_vec !== 12'b0001_1100_0100) begin
      n_fails++; $display("FAIL stall_valid_pattern: got %b want 000111000100", vld_vec);
    end
    n_checks++;
    if (rx_q !== exp_q) begin n_fails++; $display("FAIL stall_order: got %p want %p", rx_q, exp_q); end
`ifdef NOC_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd3) begin n_fails++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
`endif
  endtask

  task automatic test_gap();
    logic [33:0] b;
    do_reset();
    grant_en = 1'b1;
    b = mk(2'b01, 2'd0, 2'd0, 8'h42);
    exp_q = '{mk(2'b00, 2'd1, 2'd0, 8'h41), b, mk(2'b10, 2'd0, 2'd0, 8'h43)};
    tx_q.push_back(exp_q[0]);
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (s_req !== 5'b0 || s_pkt !== 1'b1) begin
      n_fails++; $display("FAIL gap_wait: got req=%b pkt=%b want 00000/1", s_req, s_pkt);
    end
    tx_q.push_back(exp_q[1]);
    tx_q.push_back(exp_q[2]);
    cycle();
    cycle();
    n_checks++;
    if (s_req !== 5'b01000 || s_valid !== 1'b1 || s_flit !== b) begin
      n_fails++; $display("FAIL gap_resume: got req=%b v=%b %h want 01000/1 %h", s_req, s_valid, s_flit, b);
    end
    cycle();
    cycle();
    n_checks++;
    if (rx_q !== exp_q || s_pkt !== 1'b0) begin
      n_fails++; $display("FAIL gap_order: got %p pkt=%b want %p pkt=0", rx_q, s_pkt, exp_q);
    end
  endtask

  task automatic test_full();
    do_reset();
    exp_q = '{mk(2'b00, 2'd1, 2'd0, 8'h51), mk(2'b01, 2'd0, 2'd0, 8'h52),
              mk(2'b01, 2'd0, 2'd0, 8'h53), mk(2'b01, 2'd0, 2'd0, 8'h54),
              mk(2'b10, 2'd0, 2'd0, 8'h55)};
    tx_q = exp_q;
    for (int i = 0; i < 4; i++) cycle();
    cycle();
    n_checks++;
    if (s_ready !== 1'b0) begin n_fails++; $display("FAIL full_ready_low: got %b want 0", s_ready); end
    n_checks++;
    if (s_req !== 5'b01000) begin n_fails++; $display("FAIL full_req: got %b want 01000", s_req); end
    cycle();
    n_checks++;
    if (tx_q.size() !== 1) begin n_fails++; $display("FAIL full_refused: got %0d pending want 1", tx_q.size()); end
    grant_en = 1'b1;
    cycle();
    n_checks++;
    if (s_ready !== 1'b0 || s_valid !== 1'b1) begin
      n_fails++; $display("FAIL full_first_pop: got ready=%b v=%b want 0/1", s_ready, s_valid);
    end
    cycle();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fails++; $display("FAIL full_ready_back: got %b want 1", s_ready); end
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (rx_q !== exp_q) begin n_fails++; $display("FAIL full_order: got %p want %p", rx_q, exp_q); end
  endtask

  task automatic test_drop();
    logic [33:0] ht;
    logic [4:0]  req_at3;
    do_reset();
    grant_en = 1'b1;
    ht = mk(2'b11, 2'd0, 2'd1, 8'h62);
    tx_q.push_back(mk(2'b01, 2'd0, 2'd0, 8'h61));
    tx_q.push_back(ht);
    cycle();
    cycle();
    n_checks++;
    if (s_drop !== 1'b1 || s_req !== 5'b0) begin
      n_fails++; $display("FAIL drop_pulse: got drop=%b req=%b want 1/00000", s_drop, s_req);
    end
    cycle();
    cycle();
    req_at3 = s_req;
    cycle();
    cycle();
    n_checks++;
    if (drops !== 1) begin n_fails++; $display("FAIL drop_count: got %0d want 1", drops); end
    n_checks++;
    if (req_at3 !== 5'b10000) begin n_fails++; $display("FAIL drop_then_west: got %b want 10000", req_at3); end
    n_checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== ht) begin
      n_fails++; $display("FAIL drop_forwarded: got %p want only %h", rx_q, ht);
    end
  endtask

  task automatic test_grant_filter();
    logic [33:0] f;
    do_reset();
    use_ovr = 1'b1;
    grant_ovr = 5'b0;
    f = mk(2'b11, 2'd1, 2'd2, 8'h71);
    tx_q.push_back(f);
    cycle();
    cycle();
    grant_ovr = 5'b00110;
    cycle();
    n_checks++;
    if (s_req !== 5'b00010 || s_valid !== 1'b0) begin
      n_fails++; $display("FAIL gf_multihot: got req=%b v=%b want 00010/0", s_req, s_valid);
    end
    grant_ovr = 5'b00100;
    cycle();
    n_checks++;
    if (s_valid !== 1'b0) begin n_fails++; $display("FAIL gf_wrong_port: got v=%b want 0", s_valid); end
    grant_ovr = 5'b00010;
    out_ready = 1'b0;
    cycle();
    n_checks++;
    if (s_req !== 5'b00010 || s_valid !== 1'b0) begin
      n_fails++; $display("FAIL gf_not_ready: got req=%b v=%b want 00010/0", s_req, s_valid);
    end
    out_ready = 1'b1;
    cycle();
    n_checks++;
    if (s_valid !== 1'b1 || s_flit !== f) begin
      n_fails++; $display("FAIL gf_pop: got v=%b %h want 1 %h", s_valid, s_flit, f);
    end
    use_ovr = 1'b0;
    grant_en = 1'b1;
    tx_q.push_back(mk(2'b11, 2'd1, 2'd1, 8'h72));
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (s_req !== 5'b00001 || s_valid !== 1'b1) begin
      n_fails++; $display("FAIL gf_local: got req=%b v=%b want 00001/1", s_req, s_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_q.push_back(mk(2'b00, 2'd1, 2'd0, 8'h81));
    tx_q.push_back(mk(2'b01, 2'd0, 2'd0, 8'h82));
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (s_req !== 5'b01000 || s_pkt !== 1'b1) begin
      n_fails++; $display("FAIL rm_pre: got req=%b pkt=%b want 01000/1", s_req, s_pkt);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (req !== 5'b0 || in_ready !== 1'b1 || pkt_active !== 1'b0) begin
      n_fails++; $display("FAIL rm_after: got req=%b rdy=%b pkt=%b want 00000/1/0", req, in_ready, pkt_active);
    end
`ifdef NOC_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fails++; $display("FAIL rm_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    rst_n = 1'b1;
    grant_en = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (s_req !== 5'b0 || rx_q.size() !== 0) begin
      n_fails++; $display("FAIL rm_discarded: got req=%b rx=%0d want 00000/0", s_req, rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_multi_flit();
    test_stall();
    test_gap();
    test_full();
    test_drop();
    test_grant_filter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
